alarm_ring_ctrl: RTL and testbench

- Downstream consumer of the alarm clock's `alarm` output.
- Turns the raw match indication into a user-facing ringing sequence: a beeping buzzer, snooze re-arm, stop/dismiss and an auto-timeout.
- All timing derives from a one-cycle seconds strobe shared with the clock core.
- Sits between the alarm clock and the buzzer/LED drivers.

---
 rtl/alarm_ring_ctrl.sv | 138 +++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing sequencer: beeping ring, snooze re-arm, stop and auto-timeout, timed by sec_tick.
// Optional macro SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_ring_ctrl #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_count,
  output logic       timed_out
);

  localparam int MAX_SEC = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int CNT_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] ring_sec_reg, ring_sec_next;
  logic [CNT_W-1:0] snz_sec_reg, snz_sec_next;
  logic             phase_reg, phase_next;
  logic [3:0]       snooze_count_reg, snooze_count_next;
  logic             timed_out_reg, timed_out_next;
  logic             buzzer_reg, ringing_reg, snoozing_reg;
  logic             alarm_q_reg, snooze_q_reg, stop_q_reg;
  logic             alarm_rise, snooze_rise, stop_rise, snooze_allowed;

  assign alarm_rise  = alarm & ~alarm_q_reg;
  assign snooze_rise = snooze_btn & ~snooze_q_reg;
  assign stop_rise   = stop_btn & ~stop_q_reg;

`ifdef SNOOZE_LIMIT_EN
  assign snooze_allowed = (snooze_count_reg != 4'(MAX_SNOOZE));
`else
  // Unlimited snoozes; the limit parameter only matters in the capped build.
  logic unused_max_snooze;
  assign unused_max_snooze = (MAX_SNOOZE == 0);
  assign snooze_allowed    = 1'b1;
`endif

  always_comb begin
    state_next        = state_reg;
    ring_sec_next     = ring_sec_reg;
    snz_sec_next      = snz_sec_reg;
    phase_next        = phase_reg;
    snooze_count_next = snooze_count_reg;
    timed_out_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (alarm_rise) begin
          state_next        = RING;
          ring_sec_next     = '0;
          phase_next        = 1'b1;
          snooze_count_next = 4'd0;
        end
      end
      RING: begin
        if (stop_rise) begin
          state_next = IDLE;
        end else if (snooze_rise && snooze_allowed) begin
          state_next        = SNOOZE;
          snz_sec_next      = '0;
          snooze_count_next = (snooze_count_reg == 4'd15) ? 4'd15 : snooze_count_reg + 4'd1;
        end else if (sec_tick) begin
          if (ring_sec_reg == RING_LAST) begin
            state_next     = IDLE;
            timed_out_next = 1'b1;
          end else begin
            ring_sec_next = ring_sec_reg + 1'b1;
            phase_next    = ~phase_reg;
          end
        end
      end
      SNOOZE: begin
        if (stop_rise) begin
          state_next = IDLE;
        end else if (sec_tick) begin
          if (snz_sec_reg == SNZ_LAST) begin
            state_next    = RING;
            ring_sec_next = '0;
            phase_next    = 1'b1;
          end else begin
            snz_sec_next = snz_sec_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ring_sec_reg     <= '0;
      snz_sec_reg      <= '0;
      phase_reg        <= 1'b0;
      snooze_count_reg <= 4'd0;
      timed_out_reg    <= 1'b0;
      buzzer_reg       <= 1'b0;
      ringing_reg      <= 1'b0;
      snoozing_reg     <= 1'b0;
      alarm_q_reg      <= 1'b0;
      snooze_q_reg     <= 1'b0;
      stop_q_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ring_sec_reg     <= ring_sec_next;
      snz_sec_reg      <= snz_sec_next;
      phase_reg        <= phase_next;
      snooze_count_reg <= snooze_count_next;
      timed_out_reg    <= timed_out_next;
      buzzer_reg       <= (state_next == RING) & phase_next;
      ringing_reg      <= (state_next == RING);
      snoozing_reg     <= (state_next == SNOOZE);
      alarm_q_reg      <= alarm;
      snooze_q_reg     <= snooze_btn;
      stop_q_reg       <= stop_btn;
    end
  end

  assign buzzer       = buzzer_reg;
  assign ringing      = ringing_reg;
  assign snoozing     = snoozing_reg;
  assign snooze_count = snooze_count_reg;
  assign timed_out    = timed_out_reg;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: stimulus queues expected outputs per cycle, a monitor compares.
// Expectations follow SNOOZE_LIMIT_EN when it is defined for the build.
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       alarm = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer, ringing, snoozing, timed_out;
  logic [3:0] snooze_count;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  alarm_ring_ctrl #(.SNOOZE_SEC(3), .RING_TIMEOUT_SEC(4), .MAX_SNOOZE(2)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .alarm(alarm),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzzer(buzzer),
    .ringing(ringing), .snoozing(snoozing), .snooze_count(snooze_count),
    .timed_out(timed_out)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation tagged with the edge just completed.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      automatic exp_t e = sb.pop_front();
      automatic logic [7:0] act = {buzzer, ringing, snoozing, timed_out, snooze_count};
      n_checks++;
      if (e.cyc == cyc && act === e.v) n_pass++;
      else $display("FAIL %s: got b/r/s/t/cnt=%b want %b (cycle %0d, due %0d)", e.name, act, e.v, cyc, e.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic b, input logic r, input logic s,
                     input logic t, input logic [3:0] c);
    sb.push_back('{cyc, {b, r, s, t, c}, name});
    $display("cycle %0d: expect %s b=%0b r=%0b s=%0b t=%0b cnt=%0d", cyc, name, b, r, s, t, c);
  endtask

  // One second: three quiet clocks then a tick clock.
  task automatic run_sec();
    sec_tick = 1'b0;
    repeat (3) step();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset", 0, 0, 0, 0, 4'd0);
    reset = 1'b0;

    // Ring, beep pattern, timeout.
    alarm = 1'b1; step(); chk("ring_entry", 1, 1, 0, 0, 4'd0);
    run_sec(); chk("tick1_off", 0, 1, 0, 0, 4'd0);
    run_sec(); chk("tick2_on", 1, 1, 0, 0, 4'd0);
    run_sec(); chk("tick3_off", 0, 1, 0, 0, 4'd0);
    run_sec(); chk("timeout", 0, 0, 0, 1, 4'd0);
    step(); chk("timeout_pulse_end", 0, 0, 0, 0, 4'd0);
    step(); chk("held_alarm_no_rering", 0, 0, 0, 0, 4'd0);
    alarm = 1'b0; step();

    // Stop dismiss while alarm stays high.
    alarm = 1'b1; step(); chk("ring_for_stop", 1, 1, 0, 0, 4'd0);
    stop_btn = 1'b1; step(); chk("stop", 0, 0, 0, 0, 4'd0);
    repeat (4) step();
    chk("stop_hold_no_rering", 0, 0, 0, 0, 4'd0);
    stop_btn = 1'b0; alarm = 1'b0; step();

    // Stop on the timeout tick wins, no pulse.
    alarm = 1'b1; step(); alarm = 1'b0;
    run_sec(); run_sec(); run_sec();
    chk("pre_timeout", 0, 1, 0, 0, 4'd0);
    repeat (3) step();
    stop_btn = 1'b1; sec_tick = 1'b1; step();
    chk("stop_beats_timeout", 0, 0, 0, 0, 4'd0);
    stop_btn = 1'b0; sec_tick = 1'b0; step();
    chk("no_late_pulse", 0, 0, 0, 0, 4'd0);

    // Snooze cycles.
    alarm = 1'b1; step(); chk("ring_for_snooze", 1, 1, 0, 0, 4'd0);
    alarm = 1'b0;
    snooze_btn = 1'b1; step(); chk("snooze1", 0, 0, 1, 0, 4'd1);
    snooze_btn = 1'b0;
    run_sec(); chk("snz_sec1", 0, 0, 1, 0, 4'd1);
    run_sec(); chk("snz_sec2", 0, 0, 1, 0, 4'd1);
    run_sec(); chk("snooze_expire", 1, 1, 0, 0, 4'd1);
    snooze_btn = 1'b1; step(); chk("snooze2", 0, 0, 1, 0, 4'd2);
    snooze_btn = 1'b0;
    run_sec(); run_sec(); run_sec(); chk("resume2", 1, 1, 0, 0, 4'd2);
    snooze_btn = 1'b1; sec_tick = 1'b1; step();
`ifdef SNOOZE_LIMIT_EN
    chk("limit_hold", 0, 1, 0, 0, 4'd2);
`else
    chk("snooze3", 0, 0, 1, 0, 4'd3);
`endif
    snooze_btn = 1'b0; sec_tick = 1'b0;
    stop_btn = 1'b1; step();
`ifdef SNOOZE_LIMIT_EN
    chk("stop_keeps_count", 0, 0, 0, 0, 4'd2);
`else
    chk("stop_keeps_count", 0, 0, 0, 0, 4'd3);
`endif
    stop_btn = 1'b0; step();

    // Both buttons together: stop wins, count unchanged.
    alarm = 1'b1; step(); chk("ring_count_clear", 1, 1, 0, 0, 4'd0);
    alarm = 1'b0;
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    run_sec(); run_sec(); run_sec(); chk("resume_before_both", 1, 1, 0, 0, 4'd1);
    snooze_btn = 1'b1; stop_btn = 1'b1; step();
    chk("both_buttons", 0, 0, 0, 0, 4'd1);
    snooze_btn = 1'b0; stop_btn = 1'b0; step();

    // Reset mid-SNOOZE with alarm held; first post-reset cycle is a rise.
    alarm = 1'b1; step(); chk("ring_for_reset", 1, 1, 0, 0, 4'd0);
    snooze_btn = 1'b1; step(); chk("snooze_for_reset", 0, 0, 1, 0, 4'd1);
    snooze_btn = 1'b0; step();
    reset = 1'b1; step(); chk("reset_mid_snooze", 0, 0, 0, 0, 4'd0);
    reset = 1'b0; step(); chk("post_reset_rise", 1, 1, 0, 0, 4'd0);
    alarm = 1'b0;
    step();
    step();

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
